// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the ALU control stage and seq_alu.
//   Opcode localparams, FSM state encoding and the single-cycle ALU function.
//   Build option SEQ_ALU_DIV_EN adds the DIV state to the encoding.
package alu_pkg;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_SLL  = 4'b0101;
   localparam logic [3:0] OP_SRL  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_MUL  = 4'b1000;
   localparam logic [3:0] OP_DIVU = 4'b1001;
   localparam logic [3:0] OP_REMU = 4'b1010;

   localparam int unsigned ITERS = 32;

`ifdef SEQ_ALU_DIV_EN
   typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2, DIV = 2'd3} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2} state_t;
`endif

   // One-cycle ops. MUL/DIVU/REMU land here only when they are not iterated,
   // i.e. DIVU/REMU with the divider compiled out, and then return 0.
   // Unlisted opcodes behave as ADD.
   function automatic logic [31:0] alu_simple(input logic [3:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
      logic [31:0] r;
      case (op)
         OP_ADD:                   r = a + b;
         OP_SUB:                   r = a - b;
         OP_AND:                   r = a & b;
         OP_OR:                    r = a | b;
         OP_XOR:                   r = a ^ b;
         OP_SLL:                   r = a << b[4:0];
         OP_SRL:                   r = a >> b[4:0];
         OP_SLT:                   r = {31'd0, $signed(a) < $signed(b)};
         OP_MUL, OP_DIVU, OP_REMU: r = '0;
         default:                  r = a + b;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/div_step.sv
// div_step -- one restoring-division iteration (combinational).
//   rem_i/quo_i : partial remainder and dividend/quotient shift register
//   div_i       : divisor
//   rem_o/quo_o : values after shifting in the next dividend bit
// A zero divisor always "fits", so 32 steps yield quo=all ones, rem=dividend.
module div_step (
   input  logic [31:0] rem_i,
   input  logic [31:0] quo_i,
   input  logic [31:0] div_i,
   output logic [31:0] rem_o,
   output logic [31:0] quo_o
);
   logic [32:0] rem_sh;
   logic [32:0] diff;

   assign rem_sh = {rem_i, quo_i[31]};
   assign diff   = rem_sh - {1'b0, div_i};

   always_comb begin
      if (!diff[32]) begin
         rem_o = diff[31:0];
         quo_o = {quo_i[30:0], 1'b1};
      end else begin
         rem_o = rem_sh[31:0];
         quo_o = {quo_i[30:0], 1'b0};
      end
   end
endmodule

// File: rtl/seq_alu.sv
// seq_alu -- sequential ALU: one-cycle simple ops, 32-iteration shift-add MUL
//   and (with SEQ_ALU_DIV_EN) 32-iteration restoring DIVU/REMU.
//   clk, reset (async active-low), start_i, ALU_Operation_i[3:0], A_i, B_i
//   result_o : registered result, held until the next completion
//   zero_o   : result_o == 0
//   busy_o   : high in MUL/DIV; done_o : high in DONE (one cycle per op)
module seq_alu import alu_pkg::*; (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_i,
   input  logic [3:0]  ALU_Operation_i,
   input  logic [31:0] A_i,
   input  logic [31:0] B_i,
   output logic [31:0] result_o,
   output logic        zero_o,
   output logic        busy_o,
   output logic        done_o
);
   state_t      state, state_nxt;
   logic [4:0]  cnt;
   logic [31:0] acc;   // MUL: product accumulator; DIV: partial remainder
   logic [31:0] a_q;   // MUL: multiplicand (shifts left); DIV: dividend/quotient
   logic [31:0] b_q;   // MUL: multiplier (shifts right); DIV: divisor
   logic [31:0] acc_mul;
   logic        is_mul;
   logic        last;

   assign is_mul  = (ALU_Operation_i == OP_MUL);
   assign last    = (cnt == 5'd31);
   assign acc_mul = b_q[0] ? acc + a_q : acc;
   assign zero_o  = (result_o == '0);

`ifdef SEQ_ALU_DIV_EN
   logic        is_div;
   logic [3:0]  op_q;
   logic [31:0] rem_nxt, quo_nxt;

   assign is_div = (ALU_Operation_i == OP_DIVU) || (ALU_Operation_i == OP_REMU);

   div_step u_div_step (
      .rem_i (acc),
      .quo_i (a_q),
      .div_i (b_q),
      .rem_o (rem_nxt),
      .quo_o (quo_nxt)
   );
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy_o    = 1'b0;
      done_o    = 1'b0;
      case (state)
         IDLE, DONE: begin
            done_o = (state == DONE);
            if (start_i) begin
               if (is_mul) state_nxt = MUL;
`ifdef SEQ_ALU_DIV_EN
               else if (is_div) state_nxt = DIV;
`endif
               else state_nxt = DONE;
            end else begin
               state_nxt = IDLE;
            end
         end
         MUL: begin
            busy_o = 1'b1;
            if (last) state_nxt = DONE;
         end
`ifdef SEQ_ALU_DIV_EN
         DIV: begin
            busy_o = 1'b1;
            if (last) state_nxt = DONE;
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         result_o <= '0;
         cnt      <= '0;
         acc      <= '0;
         a_q      <= '0;
         b_q      <= '0;
`ifdef SEQ_ALU_DIV_EN
         op_q     <= '0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start_i) begin
                  cnt <= '0;
                  acc <= '0;
                  a_q <= A_i;
                  b_q <= B_i;
`ifdef SEQ_ALU_DIV_EN
                  op_q <= ALU_Operation_i;
                  if (!is_mul && !is_div)
`else
                  if (!is_mul)
`endif
                     result_o <= alu_simple(ALU_Operation_i, A_i, B_i);
               end
            end
            MUL: begin
               acc <= acc_mul;
               a_q <= a_q << 1;
               b_q <= b_q >> 1;
               if (last) result_o <= acc_mul;
               else      cnt      <= cnt + 5'd1;
            end
`ifdef SEQ_ALU_DIV_EN
            DIV: begin
               acc <= rem_nxt;
               a_q <= quo_nxt;
               if (last) result_o <= (op_q == OP_REMU) ? rem_nxt : quo_nxt;
               else      cnt      <= cnt + 5'd1;
            end
`endif
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu -- directed self-checking bench for seq_alu.
module tb_seq_alu;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start_i = 1'b0;
   logic [3:0]  ALU_Operation_i = '0;
   logic [31:0] A_i = '0, B_i = '0;
   logic [31:0] result_o;
   logic        zero_o, busy_o, done_o;

   int total = 0;
   int bad   = 0;

   seq_alu dut (
      .clk(clk), .reset(reset), .start_i(start_i),
      .ALU_Operation_i(ALU_Operation_i), .A_i(A_i), .B_i(B_i),
      .result_o(result_o), .zero_o(zero_o), .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present a request for exactly one rising edge; returns #1 after it.
   task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      start_i = 1'b1; ALU_Operation_i = op; A_i = a; B_i = b;
      @(posedge clk); #1;
      start_i = 1'b0;
   endtask

   // Edges waited until done_o is seen (0 = already done), busy samples seen.
   task automatic wait_done(output int n, output int nb);
      n = 0; nb = 0;
      while (!done_o && n < 100) begin
         if (busy_o) nb++;
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic run(input string tag, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp_r, input int exp_n);
      int n, nb;
      launch(op, a, b);
      wait_done(n, nb);
      chk({tag, " done"},    {31'd0, done_o}, 32'd1);
      chk({tag, " result"},  result_o, exp_r);
      chk({tag, " zero"},    {31'd0, zero_o}, {31'd0, exp_r == 32'd0});
      chk({tag, " latency"}, n, exp_n);
      chk({tag, " busy"},    nb, exp_n);
   endtask

   initial begin
      int n, nb, dones;

      // Reset state
      #2;
      chk("rst result", result_o, 32'd0);
      chk("rst zero",   {31'd0, zero_o}, 32'd1);
      chk("rst busy",   {31'd0, busy_o}, 32'd0);
      chk("rst done",   {31'd0, done_o}, 32'd0);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1;

      // Simple ops
      run("add",     OP_ADD, 32'd5, 32'd7, 32'd12, 0);
      run("sub0",    OP_SUB, 32'd5, 32'd5, 32'd0, 0);
      run("and",     OP_AND, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 0);
      run("or",      OP_OR,  32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01, 0);
      run("sll33",   OP_SLL, 32'd1, 32'd33, 32'd2, 0);
      run("srl36",   OP_SRL, 32'h8000_0000, 32'd36, 32'h0800_0000, 0);
      run("slt_neg", OP_SLT, 32'd1, 32'hFFFF_FFFF, 32'd0, 0);
      run("op1111",  4'b1111, 32'd3, 32'd4, 32'd7, 0);

      // DONE -> IDLE when start stays low
      @(posedge clk); #1;
      chk("idle done", {31'd0, done_o}, 32'd0);
      chk("idle hold", result_o, 32'd7);

      // MUL
      run("mul", OP_MUL, 32'h0001_0003, 32'h0001_0002, 32'h0005_0006, 32);

`ifdef SEQ_ALU_DIV_EN
      run("divu",   OP_DIVU, 32'd100, 32'd7, 32'd14, 32);
      run("remu",   OP_REMU, 32'd100, 32'd7, 32'd2, 32);
      run("divu/0", OP_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, 32);
      run("remu/0", OP_REMU, 32'd9, 32'd0, 32'd9, 32);
`else
      run("divu_off", OP_DIVU, 32'd100, 32'd7, 32'd0, 0);
      run("remu_off", OP_REMU, 32'd100, 32'd7, 32'd0, 0);
`endif

      // start during MUL is ignored
      launch(OP_MUL, 32'h0001_0003, 32'h0001_0002);
      repeat (5) begin @(posedge clk); #1; end
      launch(OP_SUB, 32'd1, 32'd1);
      chk("ign busy", {31'd0, busy_o}, 32'd1);
      wait_done(n, nb);
      chk("ign done",    {31'd0, done_o}, 32'd1);
      chk("ign latency", n, 32'd26);
      chk("ign result",  result_o, 32'h0005_0006);

      // Back-to-back with start held high
      start_i = 1'b1; ALU_Operation_i = OP_SLT; A_i = 32'hFFFF_FFFF; B_i = 32'd1;
      @(posedge clk); #1;
      chk("b2b slt done",   {31'd0, done_o}, 32'd1);
      chk("b2b slt result", result_o, 32'd1);
      ALU_Operation_i = OP_XOR; A_i = 32'hF0; B_i = 32'hFF;
      @(posedge clk); #1;
      start_i = 1'b0;
      chk("b2b xor done",   {31'd0, done_o}, 32'd1);
      chk("b2b xor result", result_o, 32'h0F);
      @(posedge clk); #1;
      chk("b2b end done",   {31'd0, done_o}, 32'd0);

      // Reset mid-MUL (result currently 0x0F, nonzero)
      launch(OP_MUL, 32'd3, 32'd5);
      repeat (10) begin @(posedge clk); #1; end
      chk("mid busy", {31'd0, busy_o}, 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("mid rst result", result_o, 32'd0);
      chk("mid rst zero",   {31'd0, zero_o}, 32'd1);
      chk("mid rst busy",   {31'd0, busy_o}, 32'd0);
      chk("mid rst done",   {31'd0, done_o}, 32'd0);
      @(posedge clk); @(posedge clk); #1 reset = 1'b1;
      dones = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done_o || busy_o) dones++;
      end
      chk("mid no done", dones, 32'd0);
      run("add11", OP_ADD, 32'd1, 32'd1, 32'd2, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
